// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial add scheduler
//
// Purpose: sequencer state encoding, requester id type and arbiter reset value,
//          imported by serial_add_sched.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic req_id_t;

  // last_grant resets to requester 1 so requester 0 wins the first contention
  localparam req_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/serial_addbit.sv
// rtl/serial_addbit.sv - combinational 1-bit full adder cell
//
// Purpose: the single shared adder resource that the scheduler time-multiplexes.
// Ports:
//   a, b  in  1  operand bits
//   ci    in  1  carry in
//   sum   out 1  a ^ b ^ ci
//   co    out 1  majority(a, b, ci)
module serial_addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - round-robin scheduler for a shared bit-serial adder
//
// Purpose: accepts WIDTH-bit add requests from two requesters, arbitrates
//          round-robin, adds LSB first through one serial_addbit cell (one bit
//          per clock) and presents {rsp_co, rsp_sum} = A + B + ci with the
//          owning requester id.
// Optional build macro: SERIAL_ADD_OVF_EN adds output rsp_ovf (signed overflow).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake, ready only in IDLE for the grantee
//   reqN_a, reqN_b, reqN_ci  operands and carry-in of requester N
//   rsp_valid / rsp_ready    response handshake
//   rsp_sum, rsp_co, rsp_id  result, carry-out, owning requester
//   rsp_ovf                  signed overflow (SERIAL_ADD_OVF_EN only)
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_co,
  output logic             rsp_id
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  req_id_t          id_r;
  req_id_t          last_grant;
  logic             idle;
  logic             cell_sum;
  logic             cell_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_r;
`endif

  // Ready is suppressed while rst is high so nothing looks accepted during reset.
  assign idle       = (state == IDLE) && !rst;
  assign req0_ready = idle && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_grant);

  // Operands shift right so the cell always sees bit 0; this avoids a
  // variable bit-select and works unchanged for WIDTH == 1.
  serial_addbit u_addbit (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .ci  (carry),
    .sum (cell_sum),
    .co  (cell_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  always_comb begin
    sum_shift            = sum_r >> 1;
    sum_shift[WIDTH-1]   = cell_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      sum_r      <= '0;
      carry      <= 1'b0;
      id_r       <= 1'b0;
      last_grant <= LAST_GRANT_RST;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            a_sh       <= req0_a;
            b_sh       <= req0_b;
            carry      <= req0_ci;
            id_r       <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= '0;
            state      <= RUN;
          end else if (req1_ready) begin
            a_sh       <= req1_a;
            b_sh       <= req1_b;
            carry      <= req1_ci;
            id_r       <= 1'b1;
            last_grant <= 1'b1;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_shift;
          carry <= cell_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            state <= DONE;
`ifdef SERIAL_ADD_OVF_EN
            // carry register holds the carry into the MSB during the last bit
            ovf_r <= carry ^ cell_co;
`endif
          end
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // carry stops changing once in DONE, so it is the held carry-out
  assign rsp_valid = (state == DONE);
  assign rsp_sum   = sum_r;
  assign rsp_co    = carry;
  assign rsp_id    = id_r;
`ifdef SERIAL_ADD_OVF_EN
  assign rsp_ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - self-checking bench for serial_add_sched (WIDTH=8)
module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ci = 1'b0, req1_ci = 1'b0;
  logic         rsp_valid, rsp_co, rsp_id;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         rsp_ovf;
`endif

  serial_add_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_co(rsp_co), .rsp_id(rsp_id)
`ifdef SERIAL_ADD_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           ci;
    logic [W-1:0] sum;
    bit           co;
    bit           ovf;
  } vec_t;

  vec_t tbl[8];
  int   nvec = 0;
  int   nfail = 0;
  int   both_hi = 0;

  always @(negedge clk) begin
    #1;
    if (req0_ready && req1_ready) both_hi++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits from the cycle after acceptance; returns cycles counted from the accept cycle.
  task automatic wait_rsp(output int lat);
    lat = 1;
    #1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  task automatic run_op(input vec_t v);
    int n;
    int lat;
    @(negedge clk);
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_ci = v.ci;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_ci = v.ci;
    end
    #1;
    n = 0;
    while (!(v.id ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept", (n < 20), 1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = W'($urandom); req1_b = W'($urandom);
    wait_rsp(lat);
    check("latency", lat, W + 1);
    check("sum", rsp_sum, v.sum);
    check("co", rsp_co, v.co);
    check("id", rsp_id, v.id);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf", rsp_ovf, v.ovf);
`endif
    handshake();
  endtask

  initial begin
    int grants, resps, last_cyc, lat, stale;
    bit busy_ready, stop_valid;

    tbl[0] = '{id: 0, a: 8'h03, b: 8'h05, ci: 0, sum: 8'h08, co: 0, ovf: 0};
    tbl[1] = '{id: 1, a: 8'hFF, b: 8'h01, ci: 0, sum: 8'h00, co: 1, ovf: 0};
    tbl[2] = '{id: 1, a: 8'hFF, b: 8'hFF, ci: 1, sum: 8'hFF, co: 1, ovf: 0};
    tbl[3] = '{id: 0, a: 8'h80, b: 8'h80, ci: 0, sum: 8'h00, co: 1, ovf: 1};
    tbl[4] = '{id: 0, a: 8'h55, b: 8'hAA, ci: 1, sum: 8'h00, co: 1, ovf: 0};
    tbl[5] = '{id: 1, a: 8'h12, b: 8'h34, ci: 1, sum: 8'h47, co: 0, ovf: 0};
    tbl[6] = '{id: 0, a: 8'h00, b: 8'h00, ci: 0, sum: 8'h00, co: 0, ovf: 0};
    tbl[7] = '{id: 1, a: 8'h7F, b: 8'h01, ci: 0, sum: 8'h80, co: 0, ovf: 1};

    // reset state, with both requesters asking
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_co", rsp_co, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);

    // both valid held continuously: grants alternate 0,1,0,1 every W+2 cycles
    req0_a = 8'h01; req0_b = 8'h02; req0_ci = 1'b0;
    req1_a = 8'h10; req1_b = 8'h20; req1_ci = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    grants = 0; resps = 0; last_cyc = 0; stop_valid = 0;
    for (int cyc = 0; cyc < 200 && (grants < 4 || resps < 4); cyc++) begin
      if (stop_valid) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (req0_ready || req1_ready) begin
        check("grant_order", req1_ready, grants % 2);
        if (grants > 0) check("grant_gap", cyc - last_cyc, W + 2);
        last_cyc = cyc;
        grants++;
        if (grants == 4) stop_valid = 1;
      end
      if (rsp_valid) begin
        check("alt_id", rsp_id, resps % 2);
        check("alt_sum", {rsp_co, rsp_sum}, rsp_id ? 9'h031 : 9'h003);
        resps++;
      end
      @(negedge clk);
    end
    check("alt_grants", grants, 4);
    check("alt_resps", resps, 4);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // response stall: outputs hold, no ready until the handshake
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h01; req1_ci = 1'b0;
    #1;
    check("stall_accept", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h20; req0_b = 8'h22; req0_ci = 1'b1;
    busy_ready = 0;
    lat = 1; #1;
    while (!rsp_valid && lat < 40) begin
      busy_ready |= req0_ready;
      @(negedge clk); #1;
      lat++;
    end
    check("stall_latency", lat, W + 1);
    for (int k = 0; k < 5; k++) begin
      busy_ready |= req0_ready;
      check("stall_hold", {rsp_valid, rsp_id, rsp_co, rsp_sum}, {1'b1, 1'b1, 1'b0, 8'h10});
      @(negedge clk); #1;
    end
    check("stall_no_ready", busy_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("stall_drop", rsp_valid, 0);
    check("stall_next_ready", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp(lat);
    check("stall_next", {rsp_id, rsp_co, rsp_sum}, {1'b0, 1'b0, 8'h43});
    handshake();

    // reset during the 4th RUN cycle of a req0 op
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; req0_ci = 1'b1;
    #1;
    check("abort_accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_valid", rsp_valid, 0);
    check("abort_sum", rsp_sum, 0);
    check("abort_co", rsp_co, 0);
    check("abort_id", rsp_id, 0);
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) stale++;
      @(negedge clk); #1;
    end
    check("abort_stale", stale, 0);

    // last_grant back at reset value: req0 wins contention; op completes correctly
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F; req0_ci = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h11; req1_ci = 1'b0;
    #1;
    check("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    check("post_rst_latency", lat, W + 1);
    check("post_rst_res", {rsp_id, rsp_co, rsp_sum}, {1'b0, 1'b0, 8'h4B});
    handshake();

    check("never_both_ready", both_hi, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
